// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
package usr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage : usr_pkg

// File: rtl/usr_cell.sv
// One storage bit of the universal shift register: 4:1 mux into an enabled flop.
module usr_cell
    import usr_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_t mode,
    input  logic  right_in,  // bit arriving on a right shift (from the MSB side)
    input  logic  left_in,   // bit arriving on a left shift (from the LSB side)
    input  logic  p_bit,
    output logic  q
);

    logic d_c;

    // Select the next value of this bit from the operating mode.
    always_comb begin
        d_c = q;
        unique case (mode)
            MODE_HOLD: d_c = q;
            MODE_SHR:  d_c = right_in;
            MODE_SHL:  d_c = left_in;
            MODE_LOAD: d_c = p_bit;
            default:   d_c = q;
        endcase
    end

    // Storage flop with async reset and clock enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d_c;
        end
    end

endmodule : usr_cell

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with bidirectional serial ports and
// a modulo-WIDTH shift counter that pulses frame_done after every WIDTH shifts.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in_r,
    input  logic             s_in_l,
    output logic [WIDTH-1:0] p_out,
    output logic             s_out_r,
    output logic             s_out_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    mode_t            mode_c;
    logic [WIDTH-1:0] q;
    logic             is_shift_c;
    logic             wrap_c;
    logic [CW-1:0]    cnt_nxt_c;

    assign mode_c = mode_t'(mode);

    // Bit array: each cell sees its neighbours, the ends see the serial inputs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic right_src;
        logic left_src;

        if (i == WIDTH - 1) begin : g_msb
            assign right_src = s_in_r;
        end else begin : g_mid_r
            assign right_src = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign left_src = s_in_l;
        end else begin : g_mid_l
            assign left_src = q[i-1];
        end

        usr_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .mode     (mode_c),
            .right_in (right_src),
            .left_in  (left_src),
            .p_bit    (p_in[i]),
            .q        (q[i])
        );
    end

    assign p_out   = q;
    assign s_out_r = q[0];
    assign s_out_l = q[WIDTH-1];

    // Next counter value; wraps at WIDTH-1 so non-power-of-two widths stay in range.
    always_comb begin
        is_shift_c = en && ((mode_c == MODE_SHR) || (mode_c == MODE_SHL));
        wrap_c     = is_shift_c && (shift_cnt == CW'(WIDTH - 1));
        cnt_nxt_c  = shift_cnt;
        if (en && (mode_c == MODE_LOAD)) begin
            cnt_nxt_c = '0;
        end else if (wrap_c) begin
            cnt_nxt_c = '0;
        end else if (is_shift_c) begin
            cnt_nxt_c = shift_cnt + CW'(1);
        end
    end

    // Counter and frame pulse registers; frame_done is high only after a wrapping shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            shift_cnt  <= cnt_nxt_c;
            frame_done <= wrap_c;
        end
    end

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed table, corner sequences and
// randomized traffic against an arithmetic reference model (WIDTH 8 and 5).
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] p_in = 8'h00;
    logic       s_in_r = 1'b0;
    logic       s_in_l = 1'b0;

    logic [7:0] p_out8;
    logic       sor8, sol8, fd8;
    logic [2:0] cnt8;
    logic [4:0] p_out5;
    logic       sor5, sol5, fd5;
    logic [2:0] cnt5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .p_in(p_in),
        .s_in_r(s_in_r), .s_in_l(s_in_l), .p_out(p_out8),
        .s_out_r(sor8), .s_out_l(sol8), .shift_cnt(cnt8), .frame_done(fd8)
    );

    univ_shift_reg #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .p_in(p_in[4:0]),
        .s_in_r(s_in_r), .s_in_l(s_in_l), .p_out(p_out5),
        .s_out_r(sor5), .s_out_l(sol5), .shift_cnt(cnt5), .frame_done(fd5)
    );

    // Reference model state: value, shift count and pulse, as plain integers.
    typedef struct packed {
        logic [31:0] val;
        logic [31:0] cnt;
        logic        fd;
    } mstate_t;

    mstate_t m8 = '0;
    mstate_t m5 = '0;

    function automatic mstate_t model_next(input int w, input mstate_t s, input logic e,
                                           input logic [1:0] md, input logic [31:0] pin,
                                           input logic sr, input logic sl);
        mstate_t     r;
        logic [31:0] mask;
        bit          shifted;
        mask    = (32'd1 << w) - 32'd1;
        r       = s;
        r.fd    = 1'b0;
        shifted = 1'b0;
        if (e) begin
            case (md)
                2'b01: begin r.val = (s.val >> 1) | (32'(sr) << (w - 1)); shifted = 1'b1; end
                2'b10: begin r.val = ((s.val << 1) | 32'(sl)) & mask; shifted = 1'b1; end
                2'b11: begin r.val = pin & mask; r.cnt = 32'd0; end
                default: ;
            endcase
            if (shifted) begin
                r.cnt = (s.cnt + 32'd1) % 32'(w);
                r.fd  = (r.cnt == 32'd0);
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_p8"},   32'(p_out8), m8.val);
        chk({tag, "_sor8"}, 32'(sor8),   32'(m8.val[0]));
        chk({tag, "_sol8"}, 32'(sol8),   32'(m8.val[7]));
        chk({tag, "_cnt8"}, 32'(cnt8),   m8.cnt);
        chk({tag, "_fd8"},  32'(fd8),    32'(m8.fd));
        chk({tag, "_p5"},   32'(p_out5), m5.val);
        chk({tag, "_sol5"}, 32'(sol5),   32'(m5.val[4]));
        chk({tag, "_cnt5"}, 32'(cnt5),   m5.cnt);
        chk({tag, "_fd5"},  32'(fd5),    32'(m5.fd));
    endtask

    // Drive one operation, clock it, advance the models, sample #1 after the edge.
    task automatic apply(input logic e, input logic [1:0] md, input logic [7:0] pin,
                         input logic sr, input logic sl);
        en = e; mode = md; p_in = pin; s_in_r = sr; s_in_l = sl;
        @(posedge clk);
        m8 = model_next(8, m8, e, md, 32'(pin), sr, sl);
        m5 = model_next(5, m5, e, md, 32'(pin), sr, sl);
        #1;
    endtask

    typedef struct {
        logic       e;
        logic [1:0] md;
        logic [7:0] pin;
        logic       sr;
        logic       sl;
        logic [7:0] ep;
        int         ec;
        logic       efd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [1:0] md, input logic [7:0] pin,
                       input logic sr, input logic sl, input logic [7:0] ep,
                       input int ec, input logic efd);
        vec_t v;
        v.e = e; v.md = md; v.pin = pin; v.sr = sr; v.sl = sl;
        v.ep = ep; v.ec = ec; v.efd = efd;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] ep;

        // Load then hold.
        add(1, MODE_LOAD, 8'h3C, 0, 0, 8'h3C, 0, 0);
        for (int k = 0; k < 5; k++) add(1, MODE_HOLD, 8'hFF, 1, 1, 8'h3C, 0, 0);
        // Right-shift frame of 8'hB1 with zeros entering.
        add(1, MODE_LOAD, 8'hB1, 0, 0, 8'hB1, 0, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h58, 1, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h2C, 2, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h16, 3, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h0B, 4, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h05, 5, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h02, 6, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h01, 7, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h00, 0, 1);
        add(1, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0, 0);
        // Left-shift fill with ones, then an en-low edge right after the wrap.
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h01, 1, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h03, 2, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h07, 3, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h0F, 4, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h1F, 5, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h3F, 6, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'h7F, 7, 0);
        add(1, MODE_SHL, 8'h00, 0, 1, 8'hFF, 0, 1);
        add(0, MODE_SHR, 8'h00, 0, 0, 8'hFF, 0, 0);
        // Mixed direction with enable gaps.
        add(1, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h00, 1, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h00, 2, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h00, 3, 0);
        add(0, MODE_SHR, 8'h00, 0, 0, 8'h00, 3, 0);
        add(0, MODE_SHL, 8'h00, 0, 0, 8'h00, 3, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h00, 4, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h00, 5, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h00, 6, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h00, 7, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h00, 0, 1);
        // Same again with a load after the second shift: load right after wrap.
        add(1, MODE_LOAD, 8'h00, 0, 0, 8'h00, 0, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h00, 1, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h00, 2, 0);
        add(1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0);
        add(1, MODE_SHR, 8'h00, 0, 0, 8'h52, 1, 0);
        add(0, MODE_SHL, 8'h00, 0, 0, 8'h52, 1, 0);
        add(0, MODE_LOAD, 8'hFF, 0, 0, 8'h52, 1, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'hA4, 2, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h48, 3, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h90, 4, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h20, 5, 0);
        add(1, MODE_SHL, 8'h00, 0, 0, 8'h40, 6, 0);
        add(1, MODE_HOLD, 8'h00, 0, 0, 8'h40, 6, 0);

        // Reset state.
        #1 rst = 1'b1;
        #1;
        chk("rst_p8",   32'(p_out8), 32'h0);
        chk("rst_cnt8", 32'(cnt8),   32'h0);
        chk("rst_fd8",  32'(fd8),    32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed table.
        foreach (tbl[i]) begin
            apply(tbl[i].e, tbl[i].md, tbl[i].pin, tbl[i].sr, tbl[i].sl);
            ep = tbl[i].ep;
            chk($sformatf("tbl%0d_p", i),   32'(p_out8), 32'(ep));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt8),   32'(tbl[i].ec));
            chk($sformatf("tbl%0d_fd", i),  32'(fd8),    32'(tbl[i].efd));
            chk($sformatf("tbl%0d_sor", i), 32'(sor8),   32'(ep[0]));
            chk($sformatf("tbl%0d_sol", i), 32'(sol8),   32'(ep[7]));
            cmp_model($sformatf("tblm%0d", i));
        end

        // Width 5: three frames of right shifts, counter 0..4 and a pulse every fifth shift.
        apply(1, MODE_LOAD, 8'h00, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            apply(1, MODE_SHR, 8'h00, 1'($urandom), 0);
            chk($sformatf("w5_cnt%0d", k), 32'(cnt5), 32'(k % 5));
            chk($sformatf("w5_fd%0d", k),  32'(fd5),  32'((k % 5) == 0));
        end

        // Mid-frame asynchronous reset: reach p_out=A5, shift_cnt=3 by rotating 2D right.
        apply(1, MODE_LOAD, 8'h2D, 0, 0);
        for (int k = 0; k < 3; k++) apply(1, MODE_SHR, 8'h00, m8.val[0], 0);
        chk("pre_rst_p8",   32'(p_out8), 32'hA5);
        chk("pre_rst_cnt8", 32'(cnt8),   32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_p8",   32'(p_out8), 32'h0);
        chk("arst_cnt8", 32'(cnt8),   32'h0);
        chk("arst_fd8",  32'(fd8),    32'h0);
        chk("arst_p5",   32'(p_out5), 32'h0);
        chk("arst_cnt5", 32'(cnt5),   32'h0);
        m8 = '0;
        m5 = '0;
        @(negedge clk) rst = 1'b0;
        apply(1, MODE_LOAD, 8'h5A, 0, 0);
        chk("post_rst_p8", 32'(p_out8), 32'h5A);
        cmp_model("post_rst");

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            apply(($urandom_range(0, 7) != 0), 2'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
            cmp_model($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the next generation of the fixed 4-bit parallel-in/parallel-out register. It supports hold, shift-right, shift-left and parallel-load modes over a configurable width, with serial in/out on both ends. A frame counter flags each completed WIDTH-bit serial transfer. It is the common storage/serialiser cell for the challenge's serial-link and LFSR-style blocks.

## Interface
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CW, $clog2(WIDTH), derived width of the shift counter; not overridden.

- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  clock enable; when low, all state holds.
- mode  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- p_in  in  WIDTH  parallel load data.
- s_in_r  in  1  serial input entering the MSB on a right shift.
- s_in_l  in  1  serial input entering the LSB on a left shift.
- p_out  out  WIDTH  current register contents.
- s_out_r  out  1  equals p_out[0], the bit leaving on a right shift.
- s_out_l  out  1  equals p_out[WIDTH-1], the bit leaving on a left shift.
- shift_cnt  out  CW  number of shifts since the last load or frame wrap.
- frame_done  out  1  one-cycle pulse after the WIDTH-th shift of a frame.

## Operation
- Reset, asynchronous and immediate: p_out = 0, shift_cnt = 0, frame_done = 0. This applies even in the middle of a frame.
- On a rising clk edge with en = 1:
  - Hold: p_out unchanged, shift_cnt unchanged.
  - Shift right: p_out ← {s_in_r, p_out[WIDTH-1:1]}; shift_cnt increments.
  - Shift left: p_out ← {p_out[WIDTH-2:0], s_in_l}; shift_cnt increments.
  - Load: p_out ← p_in; shift_cnt ← 0.
- Frame wrap: on a shift edge where shift_cnt == WIDTH-1:
  - shift_cnt ← 0.
  - frame_done ← 1 for exactly the following cycle.
- frame_done is 0 after every edge that is not a wrapping shift, including hold, load and en = 0 edges.
- Direction changes mid-frame do not reset the counter; each shift of either direction counts once.
- en = 0 freezes p_out and shift_cnt, and clears frame_done on the next edge.
- Counter arithmetic is modulo WIDTH, not modulo 2^CW. shift_cnt never exceeds WIDTH-1, including for non-power-of-two WIDTH.
- s_out_r and s_out_l are combinational taps of the registered p_out, with no extra logic.

## Timing
- All state is registered on rising clk. Latency is one cycle from an input sampled at edge N to p_out, shift_cnt and frame_done visible after edge N.
- frame_done is asserted during the cycle between the wrapping edge and the next edge.
- A load arriving on the cycle after a wrap is legal and clears frame_done on that edge.
- Reset deassertion: the first edge with rst low performs a normal operation.
- No combinational path from any input to any output.

## Structure
- Package usr_pkg holds:
  - Mode encodings: MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11.
  - A typedef for the mode field.
- Sub-module usr_cell: one bit of storage. It contains a 4:1 mux (hold / right neighbour / left neighbour / parallel bit) feeding a flop with async reset and enable.
  - The top level instantiates WIDTH cells in a generate loop.
  - The counter and frame_done logic live in the top level.

## Test plan
- Reset: drive rst high mid-frame with p_out = 8'hA5 and shift_cnt = 3. Require p_out = 0, shift_cnt = 0 and frame_done = 0 immediately, without waiting for a clk edge.
- Load then hold: load p_in = 8'h3C, then hold for 5 cycles. Require p_out = 8'h3C throughout and shift_cnt = 0.
- Right-shift frame: load 8'hB1, then 8 right shifts with s_in_r = 0. Require:
  - s_out_r sequence 1,0,0,0,1,1,0,1.
  - p_out = 8'h00 at the end.
  - frame_done high only in the cycle after the 8th shift, with shift_cnt = 0 in that cycle.
- Left-shift fill: from 0, 8 left shifts with s_in_l = 1. Require p_out = 8'hFF and a single frame_done pulse.
- Mixed direction and enable:
  - 3 right shifts, en low for 2 cycles, then 5 left shifts. Require shift_cnt = 3 to be held during en low, and frame_done to fire after the 5th left shift.
  - Repeat with a load after the 2nd shift. Require shift_cnt back to 0 and no frame_done.
- Non-power-of-two width: WIDTH = 5. Require shift_cnt to run 0..4 and wrap to 0, with frame_done every 5 shifts over 3 frames.
